// File: rtl/fpu_ctrl_pkg.sv
// Shared types and latency helpers for the FPU sequencer.
package fpu_ctrl_pkg;

  typedef enum logic [1:0] {
    FADD = 2'b00,
    FSUB = 2'b01,
    FMUL = 2'b10,
    FDIV = 2'b11
  } fpu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } fpu_seq_state_e;

  // Latency in FPU cycles for an opcode; the start cycle counts as cycle 1.
  function automatic int unsigned lat_of(input fpu_op_e     op,
                                         input int unsigned lat_add,
                                         input int unsigned lat_sub,
                                         input int unsigned lat_mul,
                                         input int unsigned lat_div);
    int unsigned lat;
    case (op)
      FADD:    lat = lat_add;
      FSUB:    lat = lat_sub;
      FMUL:    lat = lat_mul;
      default: lat = lat_div;
    endcase
    return lat;
  endfunction

  // Largest of the four latencies, used to size the latency counter.
  function automatic int unsigned max_lat(input int unsigned lat_add,
                                          input int unsigned lat_sub,
                                          input int unsigned lat_mul,
                                          input int unsigned lat_div);
    int unsigned m;
    m = lat_add;
    if (lat_sub > m) m = lat_sub;
    if (lat_mul > m) m = lat_mul;
    if (lat_div > m) m = lat_div;
    return m;
  endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// Loadable down-counter with a zero flag; stops at zero instead of wrapping.
module fpu_lat_counter #(
  parameter int unsigned W = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority over decrement; decrement is suppressed at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register with synchronous reset to zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fpu_seq_ctrl.sv
// Sequencer between the single-cycle core and the multi-cycle FPU.
// Handshake: a request is taken when req_valid_i is high in IDLE with
// kill_i low; fpu_start_o pulses for the first EXEC cycle; the result is
// captured on the last latency cycle and result_valid_o strobes for one
// cycle in DONE while stall_o drops so the core retires the instruction.
module fpu_seq_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LAT_ADD = 3,
  parameter int unsigned LAT_SUB = 3,
  parameter int unsigned LAT_MUL = 4,
  parameter int unsigned LAT_DIV = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic [1:0]        fpu_op_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  input  logic              kill_i,
  output logic              fpu_start_o,
  output logic [1:0]        fpu_op_o,
  output logic [DATA_W-1:0] fpu_a_o,
  output logic [DATA_W-1:0] fpu_b_o,
  input  logic [DATA_W-1:0] fpu_data_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] result_o,
  output logic              result_valid_o
);

  localparam int unsigned MAX_LAT = max_lat(LAT_ADD, LAT_SUB, LAT_MUL, LAT_DIV);
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

  fpu_seq_state_e    state_q, state_d;
  logic              start_q, start_d;
  fpu_op_e           op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;

  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              stall;
  logic              res_valid;

  // Counter preload is LAT-1 so that zero marks the final latency cycle.
  assign cnt_load_val = CNT_W'(lat_of(fpu_op_e'(fpu_op_i),
                                      LAT_ADD, LAT_SUB, LAT_MUL, LAT_DIV) - 1);

  fpu_lat_counter #(
    .W (CNT_W)
  ) u_lat_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Next-state, datapath latching and output decode.
  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    stall     = 1'b0;
    res_valid = 1'b0;

    case (state_q)
      IDLE: begin
        stall = req_valid_i;
        if (req_valid_i && !kill_i) begin
          op_d     = fpu_op_e'(fpu_op_i);
          a_d      = op_a_i;
          b_d      = op_b_i;
          cnt_load = 1'b1;
          start_d  = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        stall = 1'b1;
        if (kill_i) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          res_d   = fpu_data_i;
          state_d = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        res_valid = !kill_i;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new FP instruction must hold the PC even while reset is asserted.
    if (rst_i) begin
      stall = req_valid_i;
    end
  end

  // State and datapath registers; reset wins over kill and everything else.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      op_q    <= FADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign fpu_start_o    = start_q;
  assign fpu_op_o       = op_q;
  assign fpu_a_o        = a_q;
  assign fpu_b_o        = b_q;
  assign result_o       = res_q;
  assign stall_o        = stall;
  assign result_valid_o = res_valid;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Bench for fpu_seq_ctrl: directed scenarios followed by randomized ops,
// checked against a transaction-level timing model and a result queue.
module tb_fpu_seq_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic [1:0]   fpu_op;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         kill;
  logic [W-1:0] fpu_data;
  logic         fpu_start_o;
  logic [1:0]   fpu_op_o;
  logic [W-1:0] fpu_a_o;
  logic [W-1:0] fpu_b_o;
  logic         stall_o;
  logic         busy_o;
  logic [W-1:0] result_o;
  logic         result_valid_o;

  int           n_checks;
  int           n_pass;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res;

  fpu_seq_ctrl #(
    .DATA_W  (W),
    .LAT_ADD (3),
    .LAT_SUB (3),
    .LAT_MUL (4),
    .LAT_DIV (12)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .fpu_op_i       (fpu_op),
    .op_a_i         (op_a),
    .op_b_i         (op_b),
    .kill_i         (kill),
    .fpu_start_o    (fpu_start_o),
    .fpu_op_o       (fpu_op_o),
    .fpu_a_o        (fpu_a_o),
    .fpu_b_o        (fpu_b_o),
    .fpu_data_i     (fpu_data),
    .stall_o        (stall_o),
    .busy_o         (busy_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bench_lat(input logic [1:0] op);
    case (op)
      2'b00:   return 3;
      2'b01:   return 3;
      2'b10:   return 4;
      default: return 12;
    endcase
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample control outputs mid-cycle; any writeback strobe is scored against the queue.
  task automatic expect_cycle(input string tag, input logic e_stall, input logic e_start,
                              input logic e_busy, input logic e_rv);
    logic [W-1:0] exp_res;
    @(negedge clk);
    chk1({tag, ".stall"}, stall_o, e_stall);
    chk1({tag, ".start"}, fpu_start_o, e_start);
    chk1({tag, ".busy"}, busy_o, e_busy);
    chk1({tag, ".rvalid"}, result_valid_o, e_rv);
    if (result_valid_o === 1'b1 && exp_q.size() > 0) begin
      exp_res = exp_q.pop_front();
      chk32({tag, ".result"}, result_o, exp_res);
      last_res = exp_res;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b0;
      kill      = 1'b0;
      op_a      = $urandom;
      fpu_data  = $urandom;
      expect_cycle("idle", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  // One FP instruction from its accept cycle (k=0) to its DONE cycle (k=lat+1).
  // kill_k / rst_k > 0 abort the op in that EXEC cycle instead.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] res,
                        input int kill_k, input int rst_k, input bit noisy);
    int lat;
    lat       = bench_lat(op);
    req_valid = 1'b1;
    fpu_op    = op;
    op_a      = a;
    op_b      = b;
    kill      = 1'b0;
    fpu_data  = $urandom;
    exp_q.push_back(res);
    expect_cycle({tag, ".k0"}, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int k = 1; k <= lat; k++) begin
      req_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      fpu_op    = 2'($urandom_range(0, 3));
      op_a      = $urandom;
      op_b      = $urandom;
      fpu_data  = (k == lat) ? res : $urandom;
      if (k == kill_k) begin
        kill = 1'b1;
        expect_cycle({tag, ".kill"}, 1'b1, (k == 1), 1'b1, 1'b0);
        tick();
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        req_valid = 1'b1;
        expect_cycle({tag, ".post_kill_req"}, 1'b1, 1'b0, 1'b0, 1'b0);
        chk32({tag, ".post_kill_res"}, result_o, last_res);
        tick();
        req_valid = 1'b0;
        kill      = 1'b0;
        expect_cycle({tag, ".post_kill_idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        return;
      end
      if (k == rst_k) begin
        rst       = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        chk1({tag, ".rst_stall"}, stall_o, 1'b1);
        tick();
        rst       = 1'b0;
        req_valid = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        expect_cycle({tag, ".post_rst"}, 1'b0, 1'b0, 1'b0, 1'b0);
        chk32({tag, ".post_rst_a"}, fpu_a_o, '0);
        chk32({tag, ".post_rst_b"}, fpu_b_o, '0);
        chk32({tag, ".post_rst_res"}, result_o, '0);
        chk32({tag, ".post_rst_op"}, 32'(fpu_op_o), 32'd0);
        last_res = '0;
        tick();
        return;
      end
      expect_cycle({tag, ".exec"}, 1'b1, (k == 1), 1'b1, 1'b0);
      chk32({tag, ".fpu_a"}, fpu_a_o, a);
      chk32({tag, ".fpu_b"}, fpu_b_o, b);
      chk32({tag, ".fpu_op"}, 32'(fpu_op_o), 32'(op));
      tick();
    end
    req_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    fpu_data  = $urandom;
    expect_cycle({tag, ".done"}, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
  endtask

  // Stimulus
  initial begin
    logic [1:0]   r_op;
    int           r_lat;
    int           r_kill;
    n_checks  = 0;
    n_pass    = 0;
    last_res  = '0;
    rst       = 1'b1;
    req_valid = 1'b1;
    fpu_op    = 2'b00;
    op_a      = '0;
    op_b      = '0;
    kill      = 1'b0;
    fpu_data  = '0;

    // Reset, with stall following req_valid while reset is held
    tick();
    @(negedge clk);
    chk1("rst_req_stall", stall_o, 1'b1);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk1("rst_noreq_stall", stall_o, 1'b0);
    tick();
    rst = 1'b0;
    expect_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk32("reset_a", fpu_a_o, '0);
    chk32("reset_b", fpu_b_o, '0);
    chk32("reset_res", result_o, '0);
    chk32("reset_op", 32'(fpu_op_o), 32'd0);
    tick();

    // No requests for 10 cycles
    idle_cycles(10);

    // FADD 1.0 + 2.0, then busy low in the following cycle
    run_op("fadd", 2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 0, 0, 1'b0);
    idle_cycles(1);

    // FDIV 4.0 / 2.0 with inputs toggling during EXEC
    run_op("fdiv", 2'b11, 32'h40800000, 32'h40000000, 32'h40000000, 0, 0, 1'b1);
    idle_cycles(1);

    // Back-to-back FMUL then FSUB
    run_op("b2b_fmul", 2'b10, 32'h3FC00000, 32'h40000000, 32'h40400000, 0, 0, 1'b0);
    run_op("b2b_fsub", 2'b01, 32'h40400000, 32'h3F800000, 32'h40000000, 0, 0, 1'b0);
    idle_cycles(1);

    // Kill in the 2nd EXEC cycle of FMUL
    run_op("kill_fmul", 2'b10, 32'h41000000, 32'h40000000, 32'h41800000, 2, 0, 1'b0);

    // Reset in the 5th EXEC cycle of FDIV, then a normal FADD
    run_op("rst_fdiv", 2'b11, 32'h41200000, 32'h40000000, 32'h40A00000, 0, 5, 1'b0);
    run_op("fadd_after_rst", 2'b00, 32'h3F800000, 32'h3F800000, 32'h40000000, 0, 0, 1'b0);
    idle_cycles(1);

    // Randomized ops with occasional kills and idle gaps
    for (int i = 0; i < 24; i++) begin
      r_op   = 2'($urandom_range(0, 3));
      r_lat  = bench_lat(r_op);
      r_kill = ($urandom_range(0, 3) == 0) ? $urandom_range(1, r_lat) : 0;
      run_op("rand", r_op, $urandom, $urandom, $urandom, r_kill, 0, 1'b1);
      idle_cycles($urandom_range(0, 2));
    end

    chk32("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
